ir_conv_engine: RTL and testbench

- Parametrised successor to the pedal memory controller: per-sample sparse impulse-response (delay/reverb) convolution engine.
- On each ADC sample strobe it does the following, over a single-port memory with a request/ready handshake:
  - writes the sample into a circular delay buffer;
  - walks up to MAX_TAPS tap descriptors;
  - reads the delayed samples and multiply-accumulates them;
  - emits one saturated output sample with a valid pulse.
- Sits between the ADC/I2S front end and the DAC path. It works the same with on-chip SRAM or the off-chip memory bridge.

---
 rtl/ir_conv_pkg.sv | 47 ++++
 rtl/ir_mac.sv | 39 +++
 rtl/ir_conv_engine.sv | 198 +++++++++++++++++++
 tb/tb_ir_conv_engine.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ir_conv_pkg.sv
// rtl/ir_conv_pkg.sv - Shared FSM type, descriptor layout and arithmetic helpers for ir_conv_engine
package ir_conv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_TREQ,
        ST_TWAIT,
        ST_SREQ,
        ST_SWAIT,
        ST_OUT
    } state_t;

    // Descriptor word, MSB to LSB: delta[OFS_W] | neg | gain[GAIN_W]
    function automatic int gain_width(input int data_w, input int ofs_w);
        return data_w - ofs_w - 1;
    endfunction

    function automatic int neg_pos(input int data_w, input int ofs_w);
        return gain_width(data_w, ofs_w);
    endfunction

    function automatic int delta_lsb(input int data_w, input int ofs_w);
        return gain_width(data_w, ofs_w) + 1;
    endfunction

    // Wide enough that MAX_TAPS full-scale products can never overflow
    function automatic int acc_width(input int data_w, input int ofs_w, input int max_taps);
        return data_w + gain_width(data_w, ofs_w) + $clog2(max_taps) + 1;
    endfunction

    function automatic logic signed [63:0] saturate(input logic signed [63:0] value,
                                                    input int out_w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        if (value > hi) begin
            return hi;
        end
        if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

endpackage

// File: rtl/ir_mac.sv
// rtl/ir_mac.sv - Signed sample x unsigned gain multiply with add/subtract into a clearable accumulator
module ir_mac #(
    parameter int DATA_W = 16,
    parameter int GAIN_W = 7,
    parameter int ACC_W  = 30
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_clear,
    input  logic                     i_en,
    input  logic                     i_neg,
    input  logic signed [DATA_W-1:0] i_sample,
    input  logic [GAIN_W-1:0]        i_gain,
    output logic signed [ACC_W-1:0]  o_acc
);
    import ir_conv_pkg::*;

    logic signed [ACC_W-1:0] w_sample_ext;
    logic signed [ACC_W-1:0] w_gain_ext;
    logic signed [ACC_W-1:0] w_prod;
    logic signed [ACC_W-1:0] r_acc;

    assign w_sample_ext = ACC_W'(i_sample);
    assign w_gain_ext   = ACC_W'({1'b0, i_gain});
    assign w_prod       = w_sample_ext * w_gain_ext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (i_clear) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= i_neg ? (r_acc - w_prod) : (r_acc + w_prod);
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/ir_conv_engine.sv
// rtl/ir_conv_engine.sv - Per-sample sparse impulse-response convolution over a single-port memory
// Build option: OUT_SATURATE_EN clamps the output instead of wrapping it.
module ir_conv_engine #(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 16,
    parameter int                BUF_AW   = 12,
    parameter logic [ADDR_W-1:0] BUF_BASE = 16'h1000,
    parameter logic [ADDR_W-1:0] TAP_BASE = 16'h0000,
    parameter int                MAX_TAPS = 64,
    parameter int                OFS_W    = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             sample_valid,
    input  logic [DATA_W-1:0]                sample_in,
    input  logic [$clog2(MAX_TAPS+1)-1:0]    num_taps,
    input  logic                             bypass,
    output logic                             mem_req,
    output logic                             mem_we,
    output logic [ADDR_W-1:0]                mem_addr,
    output logic [DATA_W-1:0]                mem_wdata,
    input  logic                             mem_ready,
    input  logic                             mem_rvalid,
    input  logic [DATA_W-1:0]                mem_rdata,
    output logic                             out_valid,
    output logic [DATA_W-1:0]                out_sample,
    output logic                             busy,
    output logic                             overrun
);
    import ir_conv_pkg::*;

    localparam int NT_W      = $clog2(MAX_TAPS + 1);
    localparam int GAIN_W    = gain_width(DATA_W, OFS_W);
    localparam int NEG_POS   = neg_pos(DATA_W, OFS_W);
    localparam int DELTA_LSB = delta_lsb(DATA_W, OFS_W);
    localparam int ACC_W     = acc_width(DATA_W, OFS_W, MAX_TAPS);
    localparam logic [NT_W-1:0] MAX_TAPS_V = NT_W'(MAX_TAPS);

    state_t                   r_state;
    state_t                   w_next;
    logic [DATA_W-1:0]        r_sample;
    logic [NT_W-1:0]          r_taps;
    logic                     r_bypass;
    logic [NT_W-1:0]          r_k;
    logic [BUF_AW-1:0]        r_dsum;
    logic [BUF_AW-1:0]        r_wr_ptr;
    logic                     r_neg;
    logic [GAIN_W-1:0]        r_gain;
    logic [DATA_W-1:0]        r_out_hold;
    logic                     r_overrun;

    logic [NT_W-1:0]          w_taps_clamped;
    logic [NT_W-1:0]          w_k_inc;
    logic [BUF_AW-1:0]        w_rd_off;
    logic                     w_mac_clear;
    logic                     w_mac_en;
    logic signed [ACC_W-1:0]  w_acc;
    logic [DATA_W-1:0]        w_result_q;
    logic [DATA_W-1:0]        w_result;

    assign w_taps_clamped = (num_taps > MAX_TAPS_V) ? MAX_TAPS_V : num_taps;
    assign w_k_inc        = r_k + NT_W'(1);
    // Buffer index wraps modulo the buffer depth; aliasing of long delays is left to firmware
    assign w_rd_off       = r_wr_ptr - r_dsum;
    assign w_mac_clear    = (r_state == ST_IDLE) && sample_valid;
    assign w_mac_en       = (r_state == ST_SWAIT) && mem_rvalid;

    ir_mac #(
        .DATA_W (DATA_W),
        .GAIN_W (GAIN_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (w_mac_clear),
        .i_en     (w_mac_en),
        .i_neg    (r_neg),
        .i_sample (mem_rdata),
        .i_gain   (r_gain),
        .o_acc    (w_acc)
    );

`ifdef OUT_SATURATE_EN
    assign w_result_q = DATA_W'(saturate(64'(w_acc >>> GAIN_W), DATA_W));
`else
    assign w_result_q = DATA_W'(w_acc >>> GAIN_W);
`endif

    assign w_result = r_bypass ? r_sample : w_result_q;

    always_comb begin
        w_next    = r_state;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (r_state)
            ST_IDLE: begin
                if (sample_valid) begin
                    w_next = ST_WR;
                end
            end
            ST_WR: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = BUF_BASE + ADDR_W'(r_wr_ptr);
                mem_wdata = r_sample;
                if (mem_ready) begin
                    w_next = (r_taps != '0) ? ST_TREQ : ST_OUT;
                end
            end
            ST_TREQ: begin
                mem_req  = 1'b1;
                mem_addr = TAP_BASE + ADDR_W'(r_k);
                if (mem_ready) begin
                    w_next = ST_TWAIT;
                end
            end
            ST_TWAIT: begin
                if (mem_rvalid) begin
                    w_next = ST_SREQ;
                end
            end
            ST_SREQ: begin
                mem_req  = 1'b1;
                mem_addr = BUF_BASE + ADDR_W'(w_rd_off);
                if (mem_ready) begin
                    w_next = ST_SWAIT;
                end
            end
            ST_SWAIT: begin
                if (mem_rvalid) begin
                    w_next = (w_k_inc < r_taps) ? ST_TREQ : ST_OUT;
                end
            end
            ST_OUT: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_sample   <= '0;
            r_taps     <= '0;
            r_bypass   <= 1'b0;
            r_k        <= '0;
            r_dsum     <= '0;
            r_wr_ptr   <= '0;
            r_neg      <= 1'b0;
            r_gain     <= '0;
            r_out_hold <= '0;
            r_overrun  <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_overrun <= sample_valid && (r_state != ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    if (sample_valid) begin
                        r_sample <= sample_in;
                        r_taps   <= w_taps_clamped;
                        r_bypass <= bypass;
                        r_k      <= '0;
                        r_dsum   <= '0;
                    end
                end
                ST_TWAIT: begin
                    if (mem_rvalid) begin
                        r_dsum <= r_dsum + BUF_AW'(mem_rdata[DATA_W-1:DELTA_LSB]);
                        r_neg  <= mem_rdata[NEG_POS];
                        r_gain <= mem_rdata[GAIN_W-1:0];
                    end
                end
                ST_SWAIT: begin
                    if (mem_rvalid) begin
                        r_k <= w_k_inc;
                    end
                end
                ST_OUT: begin
                    r_out_hold <= w_result;
                    r_wr_ptr   <= r_wr_ptr + BUF_AW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign out_valid  = (r_state == ST_OUT);
    assign out_sample = (r_state == ST_OUT) ? w_result : r_out_hold;
    assign busy       = (r_state != ST_IDLE);
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_ir_conv_engine.sv
// tb/tb_ir_conv_engine.sv - Randomized self-checking bench for ir_conv_engine against a behavioural model
module tb_ir_conv_engine;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 16;
    localparam int BUF_AW   = 4;
    localparam int MAX_TAPS = 8;
    localparam int OFS_W    = 8;
    localparam int NT_W     = $clog2(MAX_TAPS + 1);
    localparam int DEPTH    = 1 << BUF_AW;
    localparam logic [15:0] BUF_BASE = 16'h1000;
    localparam logic [15:0] TAP_BASE = 16'h0000;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              sample_valid;
    logic [DATA_W-1:0] sample_in;
    logic [NT_W-1:0]   num_taps;
    logic              bypass;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;
    logic              out_valid;
    logic [DATA_W-1:0] out_sample;
    logic              busy;
    logic              overrun;

    always #5 clk = ~clk;

    ir_conv_engine #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .BUF_AW   (BUF_AW),
        .BUF_BASE (BUF_BASE),
        .TAP_BASE (TAP_BASE),
        .MAX_TAPS (MAX_TAPS),
        .OFS_W    (OFS_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_valid (sample_valid),
        .sample_in    (sample_in),
        .num_taps     (num_taps),
        .bypass       (bypass),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_ready    (mem_ready),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .out_valid    (out_valid),
        .out_sample   (out_sample),
        .busy         (busy),
        .overrun      (overrun)
    );

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    // Memory model: random acceptance, variable read latency, optional stray rvalid pulses
    logic [15:0] mem [0:65535];
    int          ready_pct = 100;
    int          dly_lo    = 1;
    int          dly_hi    = 1;
    bit          spur_en   = 0;
    bit          hold_buf  = 0;
    int          pend      = 0;
    logic [15:0] pend_data;
    bit          stall_prev = 0;
    logic        prev_we;
    logic [15:0] prev_addr;
    logic [15:0] prev_wdata;
    logic [15:0] last_buf_rd = 16'h0;

    always @(negedge clk) begin
        if (!rst_n) begin
            pend       = 0;
            mem_rvalid = 1'b0;
            mem_ready  = 1'b0;
            stall_prev = 0;
        end else begin
            if (stall_prev) begin
                check("req_stable", {mem_req, mem_we, mem_addr, mem_wdata},
                      {1'b1, prev_we, prev_addr, prev_wdata});
            end
            mem_rvalid = 1'b0;
            mem_rdata  = 16'($urandom);
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = pend_data;
                end
            end else if (spur_en && ($urandom_range(9) == 0)) begin
                mem_rvalid = 1'b1;
            end
            mem_ready = ($urandom_range(99) < ready_pct) &&
                        !(hold_buf && mem_req && !mem_we && (mem_addr >= BUF_BASE));
            if (mem_req && mem_ready) begin
                if (mem_we) begin
                    mem[mem_addr] = mem_wdata;
                end else begin
                    pend_data = mem[mem_addr];
                    pend      = $urandom_range(dly_hi, dly_lo);
                    if (mem_addr >= BUF_BASE) last_buf_rd = mem_addr;
                end
            end
            stall_prev = mem_req && !mem_ready;
            prev_we    = mem_we;
            prev_addr  = mem_addr;
            prev_wdata = mem_wdata;
        end
    end

    // Reference model: delay line as a plain array, taps as a table, integer arithmetic
    logic [15:0] tap_tbl [0:MAX_TAPS-1];
    logic [15:0] mbuf [0:DEPTH-1];
    int          mwr = 0;

    function automatic logic [15:0] ref_step(input logic [15:0] x, input int n, input bit byp);
        longint      acc;
        longint      q;
        longint      v;
        int          d;
        int          nt;
        logic [15:0] desc;
        acc = 0;
        d   = 0;
        nt  = (n > MAX_TAPS) ? MAX_TAPS : n;
        mbuf[mwr] = x;
        for (int k = 0; k < nt; k++) begin
            desc = tap_tbl[k];
            d    = (d + int'(desc[15:8])) % DEPTH;
            v    = longint'($signed(mbuf[(mwr - d + DEPTH) % DEPTH]));
            if (desc[7]) acc = acc - v * longint'(desc[6:0]);
            else         acc = acc + v * longint'(desc[6:0]);
        end
        q   = acc >>> 7;
        mwr = (mwr + 1) % DEPTH;
        if (byp) return x;
`ifdef OUT_SATURATE_EN
        if (q > 32767)  q = 32767;
        if (q < -32768) q = -32768;
`endif
        return q[15:0];
    endfunction

    task automatic load_taps();
        for (int k = 0; k < MAX_TAPS; k++) mem[TAP_BASE + 16'(k)] = tap_tbl[k];
    endtask

    task automatic random_taps();
        for (int k = 0; k < MAX_TAPS; k++)
            tap_tbl[k] = {8'($urandom_range(20)), 1'($urandom), 7'($urandom)};
        load_taps();
    endtask

    task automatic clear_buf();
        for (int i = 0; i < DEPTH; i++) begin
            mbuf[i] = 16'h0;
            mem[BUF_BASE + 16'(i)] = 16'h0;
        end
    endtask

    task automatic run_sample(input logic [15:0] x, input int n, input bit byp,
                              input int lat, output logic [15:0] got);
        logic [15:0] expv;
        int          t;
        bit          seen;
        expv = ref_step(x, n, byp);
        @(negedge clk);
        sample_valid = 1'b1;
        sample_in    = x;
        num_taps     = n[NT_W-1:0];
        bypass       = byp;
        t    = 0;
        seen = 0;
        while (!seen && t < 3000) begin
            @(negedge clk);
            sample_valid = 1'b0;
            t++;
            if (out_valid) seen = 1;
        end
        check("out_seen", 64'(seen), 64'd1);
        got = out_sample;
        if (seen) begin
            check("out_sample", out_sample, expv);
            if (lat >= 0) check("latency", 64'(t), 64'(lat));
            @(negedge clk);
            check("out_pulse", out_valid, 1'b0);
            check("out_hold", out_sample, expv);
        end
    endtask

    function automatic int zlat(input int n);
        return 2 + 4 * ((n > MAX_TAPS) ? MAX_TAPS : n);
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    logic [15:0] got;
    logic [15:0] x;
    int          n;
    bit          byp;
    int          pulses;
    int          wr_before;
    bit          found;

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0;
        for (int i = 0; i < DEPTH; i++) mbuf[i] = 16'h0;
        rst_n        = 1'b0;
        sample_valid = 1'b0;
        sample_in    = '0;
        num_taps     = '0;
        bypass       = 1'b0;
        mem_ready    = 1'b0;
        mem_rvalid   = 1'b0;
        mem_rdata    = '0;
        repeat (3) @(negedge clk);
        check("rst_out_valid",  out_valid, 1'b0);
        check("rst_out_sample", out_sample, 16'h0);
        check("rst_busy",       busy, 1'b0);
        check("rst_overrun",    overrun, 1'b0);
        check("rst_mem_bus",    {mem_req, mem_we, mem_addr, mem_wdata}, 33'h0);
        rst_n = 1'b1;

        tap_tbl[0] = {8'd0, 1'b0, 7'd127};
        load_taps();
        run_sample(16'h4000, 1, 0, 6, got);
        check("single_tap", got, 16'h3F80);
        check("buf_write0", mem[BUF_BASE], 16'h4000);

        run_sample(16'h1234, 0, 0, 2, got);
        check("zero_taps", got, 16'h0000);

        clear_buf();
        tap_tbl[0] = {8'd3, 1'b0, 7'd64};
        load_taps();
        for (int i = 0; i < 8; i++) begin
            run_sample((i == 0) ? 16'h7FFF : 16'h0000, 1, 0, 6, got);
            check("echo", got, (i == 3) ? 16'h3FFF : 16'h0000);
        end

        tap_tbl[0] = {8'd0, 1'b0, 7'd127};
        tap_tbl[1] = {8'd0, 1'b0, 7'd127};
        load_taps();
        run_sample(16'h7FFF, 2, 0, 10, got);
`ifdef OUT_SATURATE_EN
        check("saturate", got, 16'h7FFF);
`else
        check("wrap", got, 16'hFDFE);
`endif

        random_taps();
        run_sample(16'($urandom), 12, 0, zlat(12), got);
        run_sample(16'h8001, 3, 1, zlat(3), got);
        check("bypass", got, 16'h8001);

        for (int i = 0; i < 20; i++) begin
            if (i % 5 == 0) random_taps();
            n   = $urandom_range(MAX_TAPS);
            byp = ($urandom_range(9) == 0);
            run_sample(16'($urandom), n, byp, zlat(n), got);
        end

        ready_pct = 30;
        dly_lo    = 1;
        dly_hi    = 5;
        spur_en   = 1;
        for (int i = 0; i < 20; i++) begin
            if (i % 5 == 0) random_taps();
            n = $urandom_range(MAX_TAPS);
            run_sample(16'($urandom), n, 0, -1, got);
        end
        ready_pct = 100;
        dly_hi    = 1;
        spur_en   = 0;

        random_taps();
        x = 16'($urandom);
        got = ref_step(x, 2, 0);
        @(negedge clk);
        sample_valid = 1'b1;
        sample_in    = x;
        num_taps     = NT_W'(2);
        bypass       = 1'b0;
        pulses = 0;
        for (int t = 1; t <= 40; t++) begin
            @(negedge clk);
            if (out_valid) begin
                pulses++;
                check("overrun_result", out_sample, got);
            end
            if (t == 4) check("overrun_pulse", overrun, 1'b1);
            if (t == 5) check("overrun_clear", overrun, 1'b0);
            sample_valid = (t == 3);
            sample_in    = 16'($urandom);
        end
        check("overrun_one_out", 64'(pulses), 64'd1);

        tap_tbl[0] = {8'd1, 1'b0, 7'd127};
        load_taps();
        for (int i = 0; i < 20; i++) begin
            wr_before = mwr;
            run_sample(16'($urandom), 1, 0, 6, got);
            if (wr_before == 0) check("wrap_addr", last_buf_rd, BUF_BASE + 16'd15);
        end

        random_taps();
        hold_buf = 1;
        x = 16'($urandom);
        @(negedge clk);
        sample_valid = 1'b1;
        sample_in    = x;
        num_taps     = NT_W'(2);
        found = 0;
        for (int t = 0; t < 200 && !found; t++) begin
            @(negedge clk);
            sample_valid = 1'b0;
            if (mem_req && !mem_we && (mem_addr >= BUF_BASE)) found = 1;
        end
        check("sreq_reached", 64'(found), 64'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_out",  {out_valid, out_sample}, 17'h0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_bus",  {mem_req, mem_we, mem_addr, mem_wdata}, 33'h0);
        check("midrst_ovr",  overrun, 1'b0);
        mbuf[mwr] = x;
        mwr = 0;
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        hold_buf = 0;
        for (int i = 0; i < 3; i++) begin
            n = $urandom_range(1, MAX_TAPS);
            run_sample(16'($urandom), n, 0, zlat(n), got);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
